// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - job-level sequencer driving the offset generator through filter/store/line/emit phases
module conv_sequencer #(
    parameter int LINE_COUNT  = 4,
    parameter int STORE_WORDS = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       gen_done,
    output logic       gen_active,
    output logic [1:0] gen_mode,
    output logic       gen_rst,
    output logic       mac_en,
    output logic       mac_clr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] MODE_FILTER = 2'b00;
    localparam logic [1:0] MODE_STORE  = 2'b01;
    localparam logic [1:0] MODE_LINE   = 2'b10;
    localparam logic [1:0] MODE_IDLE   = 2'b11;

    localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(STORE_WORDS - 1);
    localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(LINE_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_FILTER,
        S_STORE,
        S_READ_LINE,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] store_cnt;
    logic [CNT_W-1:0] line_cnt;

    // gen_done is only consulted in phases where gen_active is forced high,
    // so the generator's idle/reset done=1 can never advance the sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            store_cnt <= '0;
            line_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_CLEAR;
                end
                S_CLEAR: begin
                    store_cnt <= '0;
                    line_cnt  <= '0;
                    state     <= S_LOAD_FILTER;
                end
                S_LOAD_FILTER: begin
                    if (gen_done) state <= S_STORE;
                end
                S_STORE: begin
                    if (in_valid) begin
                        if (store_cnt == STORE_LAST) begin
                            state <= S_READ_LINE;
                        end else begin
                            store_cnt <= store_cnt + 1'b1;
                        end
                    end
                end
                S_READ_LINE: begin
                    if (gen_done) state <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (line_cnt == LINE_LAST) begin
                            state <= S_FINISH;
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                            state    <= S_READ_LINE;
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        gen_active = 1'b0;
        gen_mode   = MODE_IDLE;
        gen_rst    = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        if (rst) begin
            gen_rst = 1'b1;
        end else begin
            busy = (state != S_IDLE);
            case (state)
                S_CLEAR: gen_rst = 1'b1;
                S_LOAD_FILTER: begin
                    gen_active = 1'b1;
                    gen_mode   = MODE_FILTER;
                end
                S_STORE: begin
                    gen_mode   = MODE_STORE;
                    in_ready   = 1'b1;
                    gen_active = in_valid;
                    mac_clr    = in_valid && (store_cnt == STORE_LAST);
                end
                S_READ_LINE: begin
                    gen_active = 1'b1;
                    gen_mode   = MODE_LINE;
                    mac_en     = 1'b1;
                end
                S_EMIT: begin
                    out_valid = 1'b1;
                    mac_clr   = out_ready && (line_cnt != LINE_LAST);
                end
                S_FINISH: done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - randomized and directed bench for conv_sequencer against a phase-level model
module tb_conv_sequencer;

    localparam int LC = 4;
    localparam int SW = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       gen_done;
    logic       gen_active;
    logic [1:0] gen_mode;
    logic       gen_rst;
    logic       mac_en;
    logic       mac_clr;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    conv_sequencer #(.LINE_COUNT(LC), .STORE_WORDS(SW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .gen_done(gen_done), .gen_active(gen_active), .gen_mode(gen_mode),
        .gen_rst(gen_rst), .mac_en(mac_en), .mac_clr(mac_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Offset generator stand-in: per-mode offset counters, done on the last offset, done=1 when idle.
    logic [7:0] fcnt = '0, scnt = '0, lcnt = '0;
    always @(posedge clk) begin
        if (rst || gen_rst) begin
            fcnt <= '0; scnt <= '0; lcnt <= '0;
        end else if (gen_active) begin
            case (gen_mode)
                2'b00: fcnt <= fcnt + 8'd1;
                2'b01: scnt <= scnt + 8'd1;
                2'b10: lcnt <= lcnt + 8'd1;
                default: ;
            endcase
        end
    end
    assign gen_done = rst || gen_rst || !gen_active ||
                      (gen_mode == 2'b00 && fcnt == 8'd3) ||
                      (gen_mode == 2'b01 && scnt == 8'(SW - 1)) ||
                      (gen_mode == 2'b10 && lcnt[1:0] == 2'd3);

    int n_tests = 0;
    int n_fail  = 0;

    localparam int P_IDLE = 0, P_CLEAR = 1, P_FILT = 2, P_STORE = 3, P_LINE = 4, P_EMIT = 5, P_FIN = 6;
    int m_phase = P_IDLE, m_beat = 0, m_words = 0, m_line = 0;
    logic e_ir, e_ga, e_grst, e_men, e_mclr, e_ov, e_busy, e_done;
    logic [1:0] e_gm;
    logic [9:0] act_v, exp_v;

    // Phase model: filter and each line last four beats, store consumes SW valid words,
    // emit waits for out_ready; compared against the DUT every cycle.
    always @(negedge clk) begin
        e_ir = 0; e_ga = 0; e_gm = 2'b11; e_grst = 0; e_men = 0; e_mclr = 0;
        e_ov = 0; e_busy = 0; e_done = 0;
        if (rst) begin
            e_grst = 1;
        end else begin
            e_busy = (m_phase != P_IDLE);
            case (m_phase)
                P_CLEAR: e_grst = 1;
                P_FILT:  begin e_ga = 1; e_gm = 2'b00; end
                P_STORE: begin
                    e_gm = 2'b01; e_ir = 1; e_ga = in_valid;
                    e_mclr = in_valid && (m_words == SW - 1);
                end
                P_LINE:  begin e_ga = 1; e_gm = 2'b10; e_men = 1; end
                P_EMIT:  begin e_ov = 1; e_mclr = out_ready && (m_line != LC - 1); end
                P_FIN:   e_done = 1;
                default: ;
            endcase
        end
        exp_v = {e_ir, e_ga, e_gm, e_grst, e_men, e_mclr, e_ov, e_busy, e_done};
        act_v = {in_ready, gen_active, gen_mode, gen_rst, mac_en, mac_clr, out_valid, busy, done};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t phase=%0d got=%b exp=%b (ir,ga,gm,grst,men,mclr,ov,busy,done)",
                     $time, m_phase, act_v, exp_v);
        end
        if (rst) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE:  if (start) m_phase = P_CLEAR;
                P_CLEAR: begin m_phase = P_FILT; m_beat = 0; m_words = 0; m_line = 0; end
                P_FILT:  begin m_beat++; if (m_beat == 4) m_phase = P_STORE; end
                P_STORE: if (in_valid) begin
                    m_words++;
                    if (m_words == SW) begin m_phase = P_LINE; m_beat = 0; end
                end
                P_LINE:  begin m_beat++; if (m_beat == 4) m_phase = P_EMIT; end
                P_EMIT:  if (out_ready) begin
                    m_line++;
                    if (m_line == LC) m_phase = P_FIN;
                    else begin m_phase = P_LINE; m_beat = 0; end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    int ov_q[$];
    int done_q[$];
    int n_grst, n_filt, n_store, n_hs, ov_seen;
    logic busy43;

    task automatic chk(input string name, input int got, input int expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, expv);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // st_mode: 0 pulse at 0, 1 held high 0..42, 2 pulses at 0 and 43.
    // iv_mode: 0 always valid, 1 toggling 0/1. or_mode: 0 always ready, 1 stalled for first 5 out_valid cycles.
    task automatic run(input int ncyc, input int iv_mode, input int or_mode, input int st_mode, input int rst_at);
        ov_q.delete(); done_q.delete();
        n_grst = 0; n_filt = 0; n_store = 0; n_hs = 0; ov_seen = 0; busy43 = 1'bx;
        for (int i = 0; i < ncyc; i++) begin
            start     = (st_mode == 0) ? (i == 0) : (st_mode == 1) ? (i <= 42) : (i == 0 || i == 43);
            in_valid  = (iv_mode == 0) ? 1'b1 : (i % 2 == 1);
            out_ready = (or_mode == 0) ? 1'b1 : (ov_seen >= 5);
            rst       = (i == rst_at);
            @(negedge clk);
            if (out_valid) begin ov_q.push_back(i); ov_seen++; end
            if (done) done_q.push_back(i);
            if (gen_rst && !rst) n_grst++;
            if (gen_active && gen_mode == 2'b00) n_filt++;
            if (gen_mode == 2'b01) n_store++;
            if (in_ready && in_valid) n_hs++;
            if (i == 43) busy43 = busy;
            @(posedge clk); #1;
        end
        start = 0; in_valid = 0; out_ready = 0; rst = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        // nominal job
        run(46, 0, 0, 0, -1);
        chk("nom_ov_count", ov_q.size(), 4);
        chk("nom_ov0", qget(ov_q, 0), 26);
        chk("nom_ov1", qget(ov_q, 1), 31);
        chk("nom_ov2", qget(ov_q, 2), 36);
        chk("nom_ov3", qget(ov_q, 3), 41);
        chk("nom_done_count", done_q.size(), 1);
        chk("nom_done_cycle", qget(done_q, 0), 42);
        chk("nom_busy_c43", int'(busy43), 0);
        chk("nom_filter_cycles", n_filt, 4);
        chk("nom_store_cycles", n_store, 16);
        chk("nom_gen_rst", n_grst, 1);

        // in_valid toggling
        run(60, 1, 0, 0, -1);
        chk("tog_store_cycles", n_store, 32);
        chk("tog_handshakes", n_hs, 16);
        chk("tog_done_cycle", qget(done_q, 0), 58);

        // sink stall in first emit
        run(52, 0, 1, 0, -1);
        chk("stall_ov0", qget(ov_q, 0), 26);
        chk("stall_ov_count", ov_q.size(), 9);
        chk("stall_ov6", qget(ov_q, 6), 36);
        chk("stall_done_cycle", qget(done_q, 0), 47);

        // back-to-back jobs
        run(90, 0, 0, 2, -1);
        chk("b2b_done_count", done_q.size(), 2);
        chk("b2b_done2_cycle", qget(done_q, 1), 85);
        chk("b2b_gen_rst", n_grst, 2);
        chk("b2b_filter_cycles", n_filt, 8);

        // reset mid read_line, then a nominal job
        run(60, 0, 0, 0, 23);
        chk("abort_done_count", done_q.size(), 0);
        run(46, 0, 0, 0, -1);
        chk("after_abort_done_cycle", qget(done_q, 0), 42);

        // start held while busy
        run(50, 0, 0, 1, -1);
        chk("held_start_done_count", done_q.size(), 1);
        chk("held_start_done_cycle", qget(done_q, 0), 42);

        // randomized traffic checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 399) == 0);
            @(posedge clk); #1;
        end
        rst = 0; start = 0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
